// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared declarations for the shared-divider scheduler:
//   - DEF_N / DEF_NREQ : default operand width and requester count
//   - state_t          : sequencer states of div_sched
//   - dp_ctrl_t        : bundle of datapath control strobes
// ----------------------------------------------------------------------------
package div_pkg;

   localparam int DEF_N    = 4;
   localparam int DEF_NREQ = 4;

   typedef enum logic [3:0] {
      IDLE,
      LOADQ,
      LOADM,
      SHIFT,
      ALU,
      QBIT,
      CHECK,
      FIX,
      DONE
   } state_t;

   typedef struct packed {
      logic ldq;
      logic ldm;
      logic clra;
      logic ldcnt;
      logic sfta;
      logic sftq;
      logic add;
      logic sub;
      logic qset;
      logic qclr;
      logic decr;
   } dp_ctrl_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request found when
// scanning upward from ptr (wrapping at NREQ-1) wins.
// Ports:
//   req     in  NREQ : request vector
//   ptr     in  IW   : highest-priority index for this pick
//   gnt_oh  out NREQ : one-hot winner (0 when no request)
//   gnt_idx out IW   : index of the winner
//   vld     out 1    : at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt_oh,
   output logic [IW-1:0]   gnt_idx,
   output logic            vld
);

   logic [IW-1:0] j;

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      vld     = 1'b0;
      j       = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = IW'((int'(ptr) + k) % NREQ);
         if (!vld && req[j]) begin
            vld        = 1'b1;
            gnt_oh[j]  = 1'b1;
            gnt_idx    = j;
         end
      end
   end

endmodule

// File: rtl/div_sched.sv
// ----------------------------------------------------------------------------
// div_sched
// Shared-divider scheduler. Arbitrates NREQ requesters round-robin onto one
// non-restoring divider datapath, sequences its strobes and returns the
// result with a one-hot completion pulse.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   req                : level requests, one per requester
//   dividend, divisor  : packed operands, slice i for requester i
//   gnt, done          : one-hot single-cycle grant / completion pulses
//   quot, rem, div0    : result, valid while done != 0
//   dp_data, dp_*      : operand bus and control strobes to the datapath
//   dp_a_neg, dp_eqz   : datapath A sign and counter-zero status
//   dp_a, dp_q         : datapath A (low N bits) and Q registers
// ----------------------------------------------------------------------------
module div_sched
   import div_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int NREQ = DEF_NREQ
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] dividend,
   input  logic [NREQ*N-1:0] divisor,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [N-1:0]      quot,
   output logic [N-1:0]      rem,
   output logic              div0,
   output logic [N-1:0]      dp_data,
   output logic              dp_ldq,
   output logic              dp_ldm,
   output logic              dp_clra,
   output logic              dp_ldcnt,
   output logic              dp_sfta,
   output logic              dp_sftq,
   output logic              dp_add,
   output logic              dp_sub,
   output logic              dp_qset,
   output logic              dp_qclr,
   output logic              dp_decr,
   input  logic              dp_a_neg,
   input  logic              dp_eqz,
   input  logic [N-1:0]      dp_a,
   input  logic [N-1:0]      dp_q
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] win_q, win_d;
   logic [N-1:0]    dvd_q, dvd_d;
   logic [N-1:0]    dvs_q, dvs_d;
   logic            div0_q, div0_d;
   logic            sgn_q, sgn_d;

   logic [NREQ-1:0] arb_oh;
   logic [IW-1:0]   arb_idx;
   logic            arb_vld;
   logic [N-1:0]    sel_dvd, sel_dvs;
   dp_ctrl_t        ctrl;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx),
      .vld     (arb_vld)
   );

   // Operand mux driven by the one-hot winner
   always_comb begin
      sel_dvd = '0;
      sel_dvs = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_oh[i]) begin
            sel_dvd = sel_dvd | dividend[i*N +: N];
            sel_dvs = sel_dvs | divisor[i*N +: N];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         div0_q  <= 1'b0;
         sgn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         div0_q  <= div0_d;
         sgn_q   <= sgn_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      div0_d  = div0_q;
      sgn_d   = sgn_q;

      ctrl    = '0;
      dp_data = '0;
      gnt     = '0;
      done    = '0;
      quot    = '0;
      rem     = '0;
      div0    = 1'b0;

      case (state_q)
         IDLE: begin
            if (arb_vld) begin
               win_d   = arb_oh;
               dvd_d   = sel_dvd;
               dvs_d   = sel_dvs;
               ptr_d   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
               div0_d  = (sel_dvs == '0);
               // A zero divisor skips the datapath entirely
               state_d = (sel_dvs == '0) ? DONE : LOADQ;
            end
         end
         LOADQ: begin
            dp_data    = dvd_q;
            ctrl.ldq   = 1'b1;
            ctrl.clra  = 1'b1;
            ctrl.ldcnt = 1'b1;
            gnt        = win_q;
            state_d    = LOADM;
         end
         LOADM: begin
            dp_data  = dvs_q;
            ctrl.ldm = 1'b1;
            state_d  = SHIFT;
         end
         SHIFT: begin
            ctrl.sfta = 1'b1;
            ctrl.sftq = 1'b1;
            // Sign of A before the shift picks add vs subtract next cycle
            sgn_d     = dp_a_neg;
            state_d   = ALU;
         end
         ALU: begin
            ctrl.add = sgn_q;
            ctrl.sub = !sgn_q;
            state_d  = QBIT;
         end
         QBIT: begin
            ctrl.qset = !dp_a_neg;
            ctrl.qclr = dp_a_neg;
            ctrl.decr = 1'b1;
            state_d   = CHECK;
         end
         CHECK: begin
            state_d = dp_eqz ? FIX : SHIFT;
         end
         FIX: begin
            // Restore a negative final remainder
            ctrl.add = dp_a_neg;
            state_d  = DONE;
         end
         DONE: begin
            done = win_q;
            if (div0_q) begin
               gnt  = win_q;
               quot = '1;
               rem  = dvd_q;
               div0 = 1'b1;
            end else begin
               quot = dp_q;
               rem  = dp_a;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign dp_ldq   = ctrl.ldq;
   assign dp_ldm   = ctrl.ldm;
   assign dp_clra  = ctrl.clra;
   assign dp_ldcnt = ctrl.ldcnt;
   assign dp_sfta  = ctrl.sfta;
   assign dp_sftq  = ctrl.sftq;
   assign dp_add   = ctrl.add;
   assign dp_sub   = ctrl.sub;
   assign dp_qset  = ctrl.qset;
   assign dp_qclr  = ctrl.qclr;
   assign dp_decr  = ctrl.decr;

endmodule

// File: tb/tb_div_sched.sv
// ----------------------------------------------------------------------------
// tb_div_sched
// Bench for div_sched: a behavioural non-restoring divider datapath reacts to
// the strobes, and every result is compared with plain integer division.
// ----------------------------------------------------------------------------
module tb_div_sched;

   localparam int N    = 4;
   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [NREQ*N-1:0] dividend, divisor;
   logic [NREQ-1:0]   gnt, done;
   logic [N-1:0]      quot, rem, dp_data, dp_a, dp_q;
   logic              div0;
   logic dp_ldq, dp_ldm, dp_clra, dp_ldcnt, dp_sfta, dp_sftq;
   logic dp_add, dp_sub, dp_qset, dp_qclr, dp_decr;
   logic dp_a_neg, dp_eqz;
   logic [10:0]       strb;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ldq_cnt = 0;
   int both_cnt = 0;

   // Behavioural datapath: A is N+1 bits, Q and M are N bits
   logic [N:0]   a_r = '0, a_n;
   logic [N-1:0] q_r = '0, m_r = '0, q_n;
   int           cnt_r = 0;

   assign dp_a_neg = a_r[N];
   assign dp_eqz   = (cnt_r == 0);
   assign dp_a     = a_r[N-1:0];
   assign dp_q     = q_r;
   assign strb = {dp_ldq, dp_ldm, dp_clra, dp_ldcnt, dp_sfta, dp_sftq,
                  dp_add, dp_sub, dp_qset, dp_qclr, dp_decr};

   always_comb begin
      a_n = a_r;
      q_n = q_r;
      if (dp_clra) a_n = '0;
      if (dp_ldq) q_n = dp_data;
      if (dp_sfta && dp_sftq) begin
         a_n = {a_r[N-1:0], q_r[N-1]};
         q_n = {q_r[N-2:0], 1'b0};
      end
      if (dp_add) a_n = a_r + {1'b0, m_r};
      if (dp_sub) a_n = a_r - {1'b0, m_r};
      if (dp_qset) q_n[0] = 1'b1;
      if (dp_qclr) q_n[0] = 1'b0;
   end

   always @(posedge clk) begin
      a_r <= a_n;
      q_r <= q_n;
      if (dp_ldm) m_r <= dp_data;
      if (dp_ldcnt) cnt_r <= N;
      else if (dp_decr) cnt_r <= cnt_r - 1;
      cyc <= cyc + 1;
      if (dp_ldq) ldq_cnt <= ldq_cnt + 1;
      if (dp_add && dp_sub) both_cnt <= both_cnt + 1;
   end

   always #5 clk = ~clk;

   div_sched #(.N(N), .NREQ(NREQ)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .dividend(dividend), .divisor(divisor),
      .gnt(gnt), .done(done), .quot(quot), .rem(rem), .div0(div0),
      .dp_data(dp_data), .dp_ldq(dp_ldq), .dp_ldm(dp_ldm), .dp_clra(dp_clra),
      .dp_ldcnt(dp_ldcnt), .dp_sfta(dp_sfta), .dp_sftq(dp_sftq), .dp_add(dp_add),
      .dp_sub(dp_sub), .dp_qset(dp_qset), .dp_qclr(dp_qclr), .dp_decr(dp_decr),
      .dp_a_neg(dp_a_neg), .dp_eqz(dp_eqz), .dp_a(dp_a), .dp_q(dp_q)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int r, input int a, input int b);
      dividend[r*N +: N] = N'(a);
      divisor[r*N +: N]  = N'(b);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   // Steps until gnt (use_done=0) or done (use_done=1) is non-zero
   task automatic wait_sig(input bit use_done, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i <= budget; i++) begin
         if ((use_done ? |done : |gnt) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (i < budget) step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = '0;
      dividend = '0;
      divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({gnt, done, quot, rem, div0} !== '0)
         $display("FAIL reset_out: got %h required 0", {gnt, done, quot, rem, div0});
      checks++;
      if ({strb, dp_data} !== '0)
         $display("FAIL reset_dp: got %h required 0", {strb, dp_data});
      if ({gnt, done, quot, rem, div0} !== '0 || {strb, dp_data} !== '0) errors++;
      rst_n = 1'b1;
      step();
      step();
      checks++;
      if ({gnt, done, strb} !== '0) begin
         errors++;
         $display("FAIL idle_quiet: got %h required 0", {gnt, done, strb});
      end
   endtask

   task automatic test_basic();
      int tg;
      bit ok;
      set_ops(0, 13, 4);
      req = 4'b0001;
      step();
      tg = cyc;
      checks++;
      if (gnt !== 4'b0001 || dp_ldq !== 1'b1) begin
         errors++;
         $display("FAIL basic_gnt: got gnt=%b ldq=%b required 0001/1", gnt, dp_ldq);
      end
      req = '0;
      set_ops(0, $urandom_range(0, 15), $urandom_range(0, 15));
      wait_sig(1'b1, 40, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL basic_timeout: no done within 40 cycles");
         return;
      end
      checks++;
      if (cyc - tg !== 19) begin
         errors++;
         $display("FAIL basic_latency: got %0d required 19", cyc - tg);
      end
      checks++;
      if (done !== 4'b0001 || quot !== 4'd3 || rem !== 4'd1 || div0 !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: got done=%b q=%0d r=%0d z=%b required 0001 3 1 0",
                  done, quot, rem, div0);
      end
      step();
      checks++;
      if (done !== '0) begin
         errors++;
         $display("FAIL basic_pulse: got done=%b required 0", done);
      end
   endtask

   task automatic test_restore();
      bit ok;
      set_ops(0, 5, 7);
      req = 4'b0001;
      wait_sig(1'b0, 40, ok);
      req = '0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL restore_timeout: no grant");
         return;
      end
      repeat (18) step();
      checks++;
      if (dp_add !== 1'b1 || dp_sub !== 1'b0) begin
         errors++;
         $display("FAIL restore_fix: got add=%b sub=%b required 1/0", dp_add, dp_sub);
      end
      step();
      checks++;
      if (done !== 4'b0001 || quot !== 4'd0 || rem !== 4'd5 || div0 !== 1'b0) begin
         errors++;
         $display("FAIL restore_result: got done=%b q=%0d r=%0d required 0001 0 5", done, quot, rem);
      end
      step();
   endtask

   task automatic test_div0();
      int l0;
      l0 = ldq_cnt;
      set_ops(1, 9, 0);
      req = 4'b0010;
      step();
      checks++;
      if (gnt !== 4'b0010 || done !== 4'b0010) begin
         errors++;
         $display("FAIL div0_pulse: got gnt=%b done=%b required 0010/0010", gnt, done);
      end
      checks++;
      if (quot !== 4'd15 || rem !== 4'd9 || div0 !== 1'b1) begin
         errors++;
         $display("FAIL div0_result: got q=%0d r=%0d z=%b required 15 9 1", quot, rem, div0);
      end
      req = '0;
      step();
      step();
      checks++;
      if (ldq_cnt !== l0 || {gnt, done} !== '0) begin
         errors++;
         $display("FAIL div0_noload: got ldq=%0d gnt/done=%b required %0d/0", ldq_cnt - l0 + l0, {gnt, done}, l0);
      end
   endtask

   task automatic test_round_robin();
      int a[NREQ], b[NREQ];
      int tg, prev;
      bit ok;
      logic [NREQ-1:0] exp_oh;
      do_reset();
      for (int k = 0; k < NREQ; k++) begin
         a[k] = $urandom_range(0, 15);
         b[k] = $urandom_range(1, 15);
         set_ops(k, a[k], b[k]);
      end
      req = '1;
      prev = 0;
      for (int k = 0; k < NREQ; k++) begin
         exp_oh = NREQ'(1) << k;
         wait_sig(1'b0, 40, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL rr_timeout: grant %0d missing", k);
            return;
         end
         checks++;
         if (gnt !== exp_oh) begin
            errors++;
            $display("FAIL rr_order: got %b required %b", gnt, exp_oh);
         end
         if (k > 0) begin
            checks++;
            if (cyc - prev !== 21) begin
               errors++;
               $display("FAIL rr_spacing: got %0d required 21", cyc - prev);
            end
         end
         tg = cyc;
         prev = cyc;
         req[k] = 1'b0;
         set_ops(k, $urandom_range(0, 15), $urandom_range(0, 15));
         wait_sig(1'b1, 40, ok);
         checks++;
         if (!ok || cyc - tg !== 19 || done !== exp_oh ||
             quot !== N'(a[k] / b[k]) || rem !== N'(a[k] % b[k])) begin
            errors++;
            $display("FAIL rr_result%0d: got lat=%0d done=%b q=%0d r=%0d required 19 %b %0d %0d",
                     k, cyc - tg, done, quot, rem, exp_oh, a[k] / b[k], a[k] % b[k]);
         end
      end
      step();
   endtask

   task automatic test_ptr_order();
      bit ok;
      int a2, a0, b2, b0;
      do_reset();
      set_ops(1, 7, 3);
      req = 4'b0010;
      wait_sig(1'b0, 40, ok);
      req = '0;
      wait_sig(1'b1, 40, ok);
      a2 = $urandom_range(0, 15); b2 = $urandom_range(1, 15);
      a0 = $urandom_range(0, 15); b0 = $urandom_range(1, 15);
      set_ops(2, a2, b2);
      set_ops(0, a0, b0);
      req = 4'b0101;
      wait_sig(1'b0, 40, ok);
      checks++;
      if (!ok || gnt !== 4'b0100) begin
         errors++;
         $display("FAIL ptr_first: got %b required 0100", gnt);
      end
      req[2] = 1'b0;
      wait_sig(1'b1, 40, ok);
      checks++;
      if (!ok || done !== 4'b0100 || quot !== N'(a2 / b2) || rem !== N'(a2 % b2)) begin
         errors++;
         $display("FAIL ptr_res2: got done=%b q=%0d r=%0d required 0100 %0d %0d",
                  done, quot, rem, a2 / b2, a2 % b2);
      end
      wait_sig(1'b0, 40, ok);
      checks++;
      if (!ok || gnt !== 4'b0001) begin
         errors++;
         $display("FAIL ptr_second: got %b required 0001", gnt);
      end
      req = '0;
      wait_sig(1'b1, 40, ok);
      checks++;
      if (!ok || done !== 4'b0001 || quot !== N'(a0 / b0) || rem !== N'(a0 % b0)) begin
         errors++;
         $display("FAIL ptr_res0: got done=%b q=%0d r=%0d required 0001 %0d %0d",
                  done, quot, rem, a0 / b0, a0 % b0);
      end
      step();
   endtask

   task automatic test_back_to_back();
      bit ok;
      int tg, a1, b1, a2, b2;
      a1 = $urandom_range(0, 15); b1 = $urandom_range(1, 15);
      a2 = $urandom_range(0, 15); b2 = $urandom_range(1, 15);
      set_ops(3, a1, b1);
      req = 4'b1000;
      wait_sig(1'b0, 40, ok);
      tg = cyc;
      set_ops(3, a2, b2);
      wait_sig(1'b1, 40, ok);
      checks++;
      if (!ok || done !== 4'b1000 || quot !== N'(a1 / b1) || rem !== N'(a1 % b1)) begin
         errors++;
         $display("FAIL b2b_first: got done=%b q=%0d r=%0d required 1000 %0d %0d",
                  done, quot, rem, a1 / b1, a1 % b1);
      end
      wait_sig(1'b0, 40, ok);
      checks++;
      if (!ok || gnt !== 4'b1000 || cyc - tg !== 21) begin
         errors++;
         $display("FAIL b2b_regrant: got gnt=%b gap=%0d required 1000 21", gnt, cyc - tg);
      end
      req = '0;
      wait_sig(1'b1, 40, ok);
      checks++;
      if (!ok || done !== 4'b1000 || quot !== N'(a2 / b2) || rem !== N'(a2 % b2)) begin
         errors++;
         $display("FAIL b2b_second: got done=%b q=%0d r=%0d required 1000 %0d %0d",
                  done, quot, rem, a2 / b2, a2 % b2);
      end
      step();
   endtask

   task automatic test_reset_mid();
      bit ok;
      int seen;
      set_ops(2, $urandom_range(0, 15), $urandom_range(1, 15));
      req = 4'b0100;
      wait_sig(1'b0, 40, ok);
      req = '0;
      repeat (7) step();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({gnt, done, quot, rem, div0, strb, dp_data} !== '0) begin
         errors++;
         $display("FAIL midreset_out: got %h required 0", {gnt, done, quot, rem, div0, strb, dp_data});
      end
      step();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (done !== '0) seen++;
         step();
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL midreset_nodone: got %0d done cycles required 0", seen);
      end
      set_ops(0, 15, 1);
      req = 4'b0001;
      wait_sig(1'b0, 40, ok);
      req = '0;
      wait_sig(1'b1, 40, ok);
      checks++;
      if (!ok || quot !== 4'd15 || rem !== 4'd0 || div0 !== 1'b0) begin
         errors++;
         $display("FAIL midreset_fresh: got q=%0d r=%0d z=%b required 15 0 0", quot, rem, div0);
      end
      step();
   endtask

   task automatic test_random();
      bit ok;
      int r, a, b, tg, lat, eq, er;
      logic [NREQ-1:0] exp_oh;
      for (int n = 0; n < 16; n++) begin
         r = $urandom_range(0, NREQ - 1);
         a = $urandom_range(0, 15);
         b = (n % 4 == 3) ? 0 : $urandom_range(0, 15);
         exp_oh = NREQ'(1) << r;
         set_ops(r, a, b);
         req = exp_oh;
         wait_sig(1'b0, 40, ok);
         tg = cyc;
         req = '0;
         set_ops(r, $urandom_range(0, 15), $urandom_range(0, 15));
         if (ok) wait_sig(1'b1, 40, ok);
         lat = (b == 0) ? 0 : 19;
         eq  = (b == 0) ? 15 : a / b;
         er  = (b == 0) ? a : a % b;
         checks++;
         if (!ok || cyc - tg !== lat || done !== exp_oh || quot !== N'(eq) ||
             rem !== N'(er) || div0 !== (b == 0)) begin
            errors++;
            $display("FAIL rand%0d %0d/%0d: got lat=%0d done=%b q=%0d r=%0d z=%b required %0d %b %0d %0d %0d",
                     n, a, b, cyc - tg, done, quot, rem, div0, lat, exp_oh, eq, er, b == 0);
         end
         step();
      end
      checks++;
      if (both_cnt !== 0) begin
         errors++;
         $display("FAIL add_sub_exclusive: got %0d overlaps required 0", both_cnt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_restore();
      test_div0();
      test_round_robin();
      test_ptr_order();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
